// File: rtl/pulse_train_pkg.sv
// Shared types and default sizes for the pulse train generator.
package pulse_train_pkg;

   localparam int unsigned WIDTH_DEF  = 8;
   localparam int unsigned CWIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// Load/decrement down-counter timing one phase of the pulse train.
// The last flag is registered and means "current count is 1".
module phase_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [WIDTH-1:0] count;

   // Load takes priority over decrement; the counter saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         last  <= 1'b0;
      end else if (load) begin
         count <= load_val;
         last  <= (load_val == WIDTH'(1));
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
         last  <= (count == WIDTH'(2));
      end
   end

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: N pulses of H cycles high separated by L-cycle gaps,
// followed by a one-cycle done strobe.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned CWIDTH = CWIDTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  high_len,
   input  logic [WIDTH-1:0]  low_len,
   input  logic [CWIDTH-1:0] num_pulses,
   input  logic              abort,
   output logic              out,
   output logic              busy,
   output logic              done
);

   state_t            state, state_next;
   logic [WIDTH-1:0]  high_q, low_q;
   logic [CWIDTH-1:0] pulses_left;

   logic              ph_load, ph_dec, ph_last;
   logic [WIDTH-1:0]  ph_val;
   logic              pc_load, pc_dec;

   // One counter times both phases; it is reloaded at every phase change.
   phase_counter #(.WIDTH(WIDTH)) u_phase (
      .clk      (clk),
      .reset    (reset),
      .load     (ph_load),
      .load_val (ph_val),
      .dec      (ph_dec),
      .last     (ph_last)
   );

   // Next-state and datapath control.
   always_comb begin
      state_next = state;
      ph_load    = 1'b0;
      ph_val     = high_q;
      ph_dec     = 1'b0;
      pc_load    = 1'b0;
      pc_dec     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               pc_load = 1'b1;
               if ((high_len == WIDTH'(0)) || (num_pulses == CWIDTH'(0))) begin
                  state_next = DONE;
               end else begin
                  state_next = HIGH;
                  ph_load    = 1'b1;
                  ph_val     = high_len;
               end
            end
         end
         HIGH: begin
            if (abort) begin
               state_next = IDLE;
            end else if (ph_last) begin
               pc_dec = 1'b1;
               if (pulses_left == CWIDTH'(1)) begin
                  state_next = DONE;
               end else begin
                  state_next = LOW;
                  ph_load    = 1'b1;
                  ph_val     = low_q;
               end
            end else begin
               ph_dec = 1'b1;
            end
         end
         LOW: begin
            if (abort) begin
               state_next = IDLE;
            end else if (ph_last) begin
               state_next = HIGH;
               ph_load    = 1'b1;
               ph_val     = high_q;
            end else begin
               ph_dec = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         out   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         out   <= (state_next == HIGH);
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
      end
   end

   // Train parameters latched at an accepted start; a zero gap runs as one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         high_q      <= '0;
         low_q       <= '0;
         pulses_left <= '0;
      end else if (pc_load) begin
         high_q      <= high_len;
         low_q       <= (low_len == WIDTH'(0)) ? WIDTH'(1) : low_len;
         pulses_left <= num_pulses;
      end else if (pc_dec && (pulses_left != '0)) begin
         pulses_left <= pulses_left - CWIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: a timing-formula model predicts out/busy/done every cycle.
module tb_pulse_train_gen;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned CWIDTH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  high_len = '0;
   logic [WIDTH-1:0]  low_len = '0;
   logic [CWIDTH-1:0] num_pulses = '0;
   logic              abort = 1'b0;
   logic              out, busy, done;

   pulse_train_gen #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .high_len   (high_len),
      .low_len    (low_len),
      .num_pulses (num_pulses),
      .abort      (abort),
      .out        (out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model: a train is described by its start reference edge s and its length D.
   bit m_act = 0;
   int m_s, m_h, m_l, m_n, m_d;
   logic e_out = 1'b0, e_busy = 1'b0, e_done = 1'b0;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d got=%0b want=%0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic model_update();
      int t;
      if (reset) begin
         m_act = 0;
      end else if (m_act) begin
         if (((cyc - 1 - m_s) == m_d) || abort) m_act = 0;
      end else if (start) begin
         m_act = 1;
         m_s   = cyc - 1;
         m_h   = int'(high_len);
         m_l   = (low_len == 0) ? 1 : int'(low_len);
         m_n   = int'(num_pulses);
         m_d   = (m_h == 0 || m_n == 0) ? 1 : 1 + m_n * m_h + (m_n - 1) * m_l;
      end
      if (m_act) begin
         t      = cyc - m_s;
         e_busy = 1'b1;
         e_done = (t == m_d);
         e_out  = (t < m_d) && (((t - 1) % (m_h + m_l)) < m_h);
      end else begin
         e_busy = 1'b0;
         e_done = 1'b0;
         e_out  = 1'b0;
      end
   endtask

   // One clock: model advances on the edge, DUT is compared at the falling edge.
   task automatic cycle();
      @(posedge clk);
      cyc++;
      model_update();
      @(negedge clk);
      chk("out", out, e_out);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
   endtask

   task automatic set_fields(input int h, input int l, input int n);
      high_len   = WIDTH'(h);
      low_len    = WIDTH'(l);
      num_pulses = CWIDTH'(n);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int base, done_at;
      logic [10:1] lit_out, lit_busy, lit_done;

      // Reset held with start asserted: nothing may begin.
      start = 1'b1;
      set_fields(3, 2, 2);
      idle(2);
      chk("reset_out", out, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      reset = 1'b0;
      start = 1'b0;
      idle(4);
      chk("idle_busy", busy, 1'b0);

      // Basic train H=3 L=2 N=2 pinned to hand-computed waveforms.
      lit_out  = 10'b0011100111;
      lit_busy = 10'b0111111111;
      lit_done = 10'b0100000000;
      set_fields(3, 2, 2);
      base = cyc;
      pulse_start();
      for (int t = 2; t <= 10; t++) begin
         if (cyc - base != t - 1) chk_int("basic_align", cyc - base, t - 1);
         cycle();
      end
      for (int t = 1; t <= 10; t++) begin
         if (t == 1 || t == 3 || t == 4 || t == 6 || t == 9 || t == 10) begin
            chk("lit_model_out", e_out, lit_out[10]);
         end
      end
      idle(2);

      // Re-run with literal checks in step.
      set_fields(3, 2, 2);
      pulse_start();
      chk("basic_t1_out", out, lit_out[1]);
      chk("basic_t1_busy", busy, lit_busy[1]);
      for (int t = 2; t <= 10; t++) begin
         if (t == 4) begin
            // Start with different fields mid-train must be ignored.
            start = 1'b1;
            set_fields(7, 7, 7);
         end
         cycle();
         start = 1'b0;
         if (t == 9) begin
            // Start presented during the done cycle is ignored too.
            start = 1'b1;
         end
         chk("basic_lit_out", out, lit_out[t]);
         chk("basic_lit_busy", busy, lit_busy[t]);
         chk("basic_lit_done", done, lit_done[t]);
      end
      // Earliest accepted restart.
      set_fields(1, 1, 1);
      pulse_start();
      chk("restart_out", out, 1'b1);
      idle(3);

      // Zero cases.
      set_fields(0, 3, 5);
      pulse_start();
      chk("zero_h_done", done, 1'b1);
      chk("zero_h_out", out, 1'b0);
      idle(2);
      set_fields(4, 3, 0);
      pulse_start();
      chk("zero_n_done", done, 1'b1);
      idle(2);
      set_fields(2, 0, 3);
      base = cyc;
      pulse_start();
      done_at = -1;
      for (int i = 0; i < 12; i++) begin
         if (done && done_at < 0) done_at = cyc - base;
         if (cyc - base == 3) chk("l0_gap", out, 1'b0);
         if (cyc - base == 4) chk("l0_pulse2", out, 1'b1);
         cycle();
      end
      chk_int("l0_done_edge", done_at, 9);

      // Abort at edge 5 of the basic train.
      set_fields(3, 2, 2);
      pulse_start();
      idle(4);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_out", out, 1'b0);
      idle(6);

      // Same with reset.
      pulse_start();
      idle(4);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      idle(3);
      chk("rst_no_restart", busy, 1'b0);

      // Maximum lengths; fields wander during the train.
      set_fields(255, 255, 15);
      base = cyc;
      pulse_start();
      done_at = -1;
      for (int i = 0; i < 7402; i++) begin
         if (done && done_at < 0) done_at = cyc - base;
         set_fields(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)));
         cycle();
      end
      chk_int("max_done_edge", done_at, 7396);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 299) == 0);
         set_fields(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)));
         cycle();
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      idle(40);
      chk("final_idle", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
